// File: rtl/block_transfer_unit.sv
// Multi-register block transfer (LDM/STM): one register moved per cycle, optional base writeback.
// Latency: start at edge k -> transfers k+1..k+N, writeback k+N+1 if taken, done pulse next cycle.
// No backpressure: memory and register file are assumed to complete in a single cycle.
module block_transfer_unit (
    input  logic        clk,
    input  logic        Reset,
    input  logic        start,
    input  logic        is_load,
    input  logic        pre,
    input  logic        up,
    input  logic        wb,
    input  logic [3:0]  Rn,
    input  logic [15:0] reg_list,
    input  logic [31:0] base_val,
    output logic [3:0]  rf_ra,
    input  logic [31:0] rf_rd,
    output logic [3:0]  rf_wa,
    output logic [31:0] rf_wd,
    output logic        rf_we,
    output logic        pc_we,
    output logic [31:0] pc_wd,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_WB, S_DONE} state_t;

    state_t      state_q, state_d;
    logic        is_load_q, is_load_d;
    logic        wb_q, wb_d;
    logic [3:0]  rn_q, rn_d;
    logic [15:0] list_q, list_d;
    logic [15:0] mask_q, mask_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] base_q, base_d;
    logic [31:0] wb_val_q, wb_val_d;

    logic [4:0]  cnt;
    logic [31:0] span;
    logic [31:0] start_addr;
    logic [3:0]  cur_idx;
    logic        last_xfer;
    logic        do_wb;

    always_comb begin
        cnt = 5'd0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + {4'd0, reg_list[i]};
        end
    end

    assign span = {25'd0, cnt, 2'b00};

    always_comb begin
        unique case ({pre, up})
            2'b01:   start_addr = base_val;
            2'b11:   start_addr = base_val + 32'd4;
            2'b00:   start_addr = base_val - span + 32'd4;
            default: start_addr = base_val - span;
        endcase
    end

    // Lowest remaining set bit of the mask is the register moved this cycle.
    always_comb begin
        cur_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (mask_q[i]) begin
                cur_idx = 4'(i);
            end
        end
    end

    assign last_xfer = ((mask_q & (mask_q - 16'd1)) == 16'd0);
    // A load that overwrites the base register wins over writeback.
    assign do_wb     = wb_q && !(is_load_q && list_q[rn_q]);

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= S_IDLE;
            is_load_q <= 1'b0;
            wb_q      <= 1'b0;
            rn_q      <= 4'd0;
            list_q    <= 16'd0;
            mask_q    <= 16'd0;
            addr_q    <= 32'd0;
            base_q    <= 32'd0;
            wb_val_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            is_load_q <= is_load_d;
            wb_q      <= wb_d;
            rn_q      <= rn_d;
            list_q    <= list_d;
            mask_q    <= mask_d;
            addr_q    <= addr_d;
            base_q    <= base_d;
            wb_val_q  <= wb_val_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (reg_list == 16'd0) ? S_DONE : S_XFER;
                end
            end
            S_XFER: begin
                if (last_xfer) begin
                    state_d = do_wb ? S_WB : S_DONE;
                end
            end
            S_WB:    state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        is_load_d = is_load_q;
        wb_d      = wb_q;
        rn_d      = rn_q;
        list_d    = list_q;
        mask_d    = mask_q;
        addr_d    = addr_q;
        base_d    = base_q;
        wb_val_d  = wb_val_q;
        if (state_q == S_IDLE && start) begin
            is_load_d = is_load;
            wb_d      = wb;
            rn_d      = Rn;
            list_d    = reg_list;
            mask_d    = reg_list;
            addr_d    = start_addr;
            base_d    = base_val;
            wb_val_d  = up ? (base_val + span) : (base_val - span);
        end else if (state_q == S_XFER) begin
            mask_d = mask_q & ~(16'd1 << cur_idx);
            addr_d = addr_q + 32'd4;
        end
    end

    always_comb begin
        rf_ra     = 4'd0;
        rf_wa     = 4'd0;
        rf_wd     = 32'd0;
        rf_we     = 1'b0;
        pc_we     = 1'b0;
        pc_wd     = 32'd0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_we    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            S_XFER: begin
                busy     = 1'b1;
                rf_ra    = cur_idx;
                mem_addr = addr_q;
                if (!is_load_q) begin
                    // The base register is stored with its value at request time.
                    mem_wdata = (cur_idx == rn_q) ? base_q : rf_rd;
                    mem_we    = 1'b1;
                end else if (cur_idx == 4'd15) begin
                    pc_wd = mem_rdata;
                    pc_we = 1'b1;
                end else begin
                    rf_wa = cur_idx;
                    rf_wd = mem_rdata;
                    rf_we = 1'b1;
                end
            end
            S_WB: begin
                busy  = 1'b1;
                rf_wa = rn_q;
                rf_wd = wb_val_q;
                rf_we = (rn_q != 4'd15);
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/block_transfer_unit.md
BLOCK_TRANSFER_UNIT -- requirements
Module: block_transfer_unit

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock; Reset  input  1  asynchronous, active-low reset.
REQ-002 SHALL have ports: start  input  1  request pulse; is_load  input  1  1=LDM, 0=STM; pre  input  1  P bit; up  input  1  U bit; wb  input  1  W bit.
REQ-003 SHALL have ports: Rn  input  4  base register index; reg_list  input  16  register mask, bit i = Ri; base_val  input  32  current Rn value.
REQ-004 SHALL have ports: rf_ra  output  4  register-file read address; rf_rd  input  32  register-file read data, combinational from rf_ra, R15 returns PC+8.
REQ-005 SHALL have ports: rf_wa  output  4; rf_wd  output  32; rf_we  output  1  register-file write port; pc_we  output  1; pc_wd  output  32  R15 load path.
REQ-006 SHALL have ports: mem_addr  output  32; mem_wdata  output  32; mem_we  output  1; mem_rdata  input  32  combinational read data for mem_addr.
REQ-007 SHALL have ports: busy  output  1; done  output  1.

Function
REQ-010 SHALL implement states IDLE, XFER, WB, DONE.
REQ-011 IDLE: start=1 at a posedge SHALL latch all request inputs, compute N=popcount(reg_list), and go to XFER; if N=0, go to DONE instead.
REQ-012 Start address SHALL be: IA (pre=0,up=1) base; IB (1,1) base+4; DA (0,0) base-4N+4; DB (1,0) base-4N; all mod 2^32.
REQ-013 Registers SHALL transfer lowest index first, one per XFER cycle, to ascending word addresses (addr+4 per transfer, wrap at 2^32).
REQ-014 XFER store: rf_ra=current index, mem_addr=current addr, mem_wdata=rf_rd, mem_we=1 for that cycle only.
REQ-015 XFER load, index!=15: rf_wa=index, rf_wd=mem_rdata, rf_we=1; index=15: pc_wd=mem_rdata, pc_we=1, rf_we=0.
REQ-016 After the last transfer: go to WB if wb=1 and not (is_load=1 and reg_list[Rn]=1); otherwise go to DONE.
REQ-017 WB: rf_wa=Rn, rf_wd=base+4N (up=1) or base-4N (up=0), rf_we=1 for one cycle; Rn=15 SHALL suppress the write (rf_we=0).
REQ-018 DONE: done=1 for exactly one cycle, then IDLE.
REQ-019 busy SHALL be 1 in XFER and WB, 0 in IDLE and DONE.
REQ-020 start SHALL be ignored outside IDLE; request inputs SHALL NOT be resampled mid-operation.
REQ-021 Latency: start sampled at edge k; transfers at cycles k+1..k+N; WB (if any) at k+N+1; done in the following cycle.
REQ-022 mem_we, rf_we and pc_we SHALL be 0 in IDLE and DONE; at most one of rf_we, pc_we is 1 per cycle.
REQ-023 STM with Rn in reg_list SHALL store the original base_val for Rn.

Reset
REQ-030 Reset=0 SHALL asynchronously force IDLE and clear all internal address, count and mask registers.
REQ-031 While in reset or IDLE, all outputs SHALL be 0, including busy, done, mem_we, rf_we and pc_we.
REQ-032 Reset asserted mid-operation SHALL abort with no further write strobes; no done pulse SHALL be issued.

Verification
REQ-040 STMIA, Rn=13, base=0x1000, list=0x000E, wb=1, R1..R3 = 0x11/0x22/0x33: bench SHALL check mem writes 0x11@0x1000, 0x22@0x1004, 0x33@0x1008, then R13<=0x100C, then done.
REQ-041 LDMDB, base=0x2000, list=0x8003, wb=0, mem returns addr value: bench SHALL check R0<=0x1FF4, R1<=0x1FF8, pc_we with 0x1FFC, and rf_we never asserted for index 15.
REQ-042 LDMIA with Rn=4 in list=0x0010, wb=1: bench SHALL check R4<=loaded value and no WB cycle; done 2 cycles after start edge.
REQ-043 Empty list, start=1: bench SHALL check done at k+1 with no mem_we, rf_we or pc_we.
REQ-044 Full list 0xFFFF STMIB, base=0xFFFFFFF0: bench SHALL check the addresses wrap through 0x0, with 16 consecutive mem_we cycles.
REQ-045 Reset low during the 3rd XFER cycle: bench SHALL check strobes drop immediately, there is no done pulse, and the next start operates normally.
